// File: rtl/div_seq_ctrl.sv
// Iterative restoring DIV/DIVU sequencer: one quotient bit per cycle, result at T+34 (T+2 on divide-by-zero).
// Holds EX via stallreq_o until the result is ready; the result is held in END while start_i stays high.
module div_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W:0]   work_q;
  logic [DATA_W-1:0]   divisor_q;
  logic                signed_q;
  logic                neg1_q;
  logic                neg2_q;
  logic [2*DATA_W-1:0] result_q;
  logic                ready_q;

  logic [DATA_W-1:0]   mag1_d;
  logic [DATA_W-1:0]   mag2_d;
  logic [DATA_W+1:0]   trial_d;
  logic [2*DATA_W:0]   work_d;
  logic [DATA_W-1:0]   quo_d;
  logic [DATA_W-1:0]   rem_d;

  always_comb begin
    mag1_d  = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    mag2_d  = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    // Upper DATA_W+1 bits of the left-shifted register, with a spare top bit acting as the sign of the trial
    trial_d = work_q[2*DATA_W:DATA_W-1] - {2'b00, divisor_q};
    if (trial_d[DATA_W+1]) begin
      work_d = {work_q[2*DATA_W-1:0], 1'b0};
    end else begin
      work_d = {trial_d[DATA_W:0], work_q[DATA_W-2:0], 1'b1};
    end
    quo_d = (signed_q && (neg1_q ^ neg2_q)) ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
    rem_d = (signed_q && neg1_q) ? -work_q[2*DATA_W-1:DATA_W] : work_q[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (start_i && !annul_i) begin
            signed_q  <= signed_div_i;
            neg1_q    <= opdata1_i[DATA_W-1];
            neg2_q    <= opdata2_i[DATA_W-1];
            work_q    <= {{(DATA_W+1){1'b0}}, mag1_d};
            divisor_q <= mag2_d;
            cnt_q     <= '0;
            state_q   <= (opdata2_i == '0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: begin
          result_q <= '0;
          ready_q  <= 1'b1;
          state_q  <= S_END;
        end
        S_ON: begin
          if (annul_i) begin
            ready_q <= 1'b0;
            state_q <= S_FREE;
          end else if (cnt_q == CNT_W'(DATA_W)) begin
            result_q <= {rem_d, quo_d};
            ready_q  <= 1'b1;
            state_q  <= S_END;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q + CNT_W'(1);
          end
        end
        S_END: begin
          if (!start_i || annul_i) begin
            ready_q  <= 1'b0;
            result_q <= '0;
            state_q  <= S_FREE;
          end
        end
        default: state_q <= S_FREE;
      endcase
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = ((state_q == S_FREE) && start_i && !annul_i) ||
                      (state_q == S_ON) || (state_q == S_BYZERO);

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for the HI/LO path: runs a 32-bit signed or unsigned iterative restoring division for DIV/DIVU, one quotient bit per cycle.
- Sits beside the EX stage. Holds the pipeline through a stall request until the result is ready.
- Delivers {remainder, quotient} as a HI/LO pair. EX forwards it down the pipe with the HI/LO write enable toward MEM/WB.

Parameters:
- DATA_W, 32, operand width; quotient and remainder each DATA_W bits
- CNT_W, 6, iteration counter width; must hold DATA_W+1

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  division requested by the instruction in EX; held high until ready_o is consumed
- annul_i  in  1  cancel the operation in progress (flush/exception)
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  DATA_W  dividend, sampled only on accepted start
- opdata2_i  in  DATA_W  divisor, sampled only on accepted start
- result_o  out  2*DATA_W  {remainder (HI), quotient (LO)}, registered
- ready_o  out  1  result_o valid, registered
- stallreq_o  out  1  pipeline stall request, combinational

Behaviour:
- States:
  - FREE: idle.
  - BYZERO: divisor was zero.
  - ON: iterating.
  - END: result held.
- Reset, when rst=1 at an edge:
  - State goes to FREE, counter to 0, working register to 0.
  - result_o = 0, ready_o = 0.
  - rst has priority in every state, including mid-operation.
- FREE:
  - If start_i=1 and annul_i=0:
    - Latch signed_div_i and the operand signs.
    - Load the operand magnitudes (two's-complement negate if signed and negative).
    - If opdata2_i=0, go to BYZERO; otherwise go to ON with cnt=0.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- BYZERO: next cycle go to END with result_o=0.
- ON, iteration:
  - Working register is 2*DATA_W+1 bits; the dividend magnitude is loaded into the low bits at start.
  - Each cycle with cnt<DATA_W: shift left by 1 and trial-subtract the divisor magnitude from the upper DATA_W+1 bits.
  - If the difference is non-negative, keep it and set the quotient bit to 1; otherwise set the quotient bit to 0.
  - Increment cnt after each iteration.
- ON, completion (cnt==DATA_W): sign-fix and register the result, then go to END.
  - Quotient is negated if signed and sign(dividend) XOR sign(divisor).
  - Remainder is negated if signed and the dividend was negative.
  - Load result_o = {rem, quo}.
- ON, cancellation: annul_i=1 in any ON cycle sends the block to FREE next cycle. No result, ready_o stays 0.
- END:
  - ready_o = 1 and result_o is held stable.
  - If start_i=0, go to FREE next cycle; ready_o and result_o clear to 0 in that cycle.
  - If start_i stays 1, remain in END.
  - annul_i in END behaves like start_i=0.
- Latency, with start accepted at edge T:
  - ON occupies T+1..T+33.
  - END and ready_o=1 first seen in cycle T+34.
  - Divide-by-zero: END at T+2.
- stallreq_o = (FREE & start_i & ~annul_i) | ON | BYZERO.
  - 0 in END, so the pipeline advances in the cycle ready_o=1.
- Edge cases:
  - Operands changing while ON or END have no effect.
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000 and remainder 0 (wraps, no trap).
  - Back-to-back divisions need one FREE cycle between them.

Test Plan:
- Unsigned: DIVU 100/7, start held → stallreq_o high 34 cycles; ready_o at T+34; result_o = 0x00000002_0000000E; FREE one cycle after start_i drops.
- Signed: DIV -7 (0xFFFFFFF9) / 2 → result_o = 0xFFFFFFFF_FFFFFFFD. DIV 7 / -2 → result_o = 0x00000001_FFFFFFFD.
- Divide by zero: DIV 5/0 → ready_o at T+2, result_o = 0, stallreq_o high for T and T+1 only.
- Annul mid-operation: DIVU 0xFFFFFFFF/3, annul_i pulse at T+10 → FREE at T+11, ready_o never asserts; a new DIVU 9/3 then gives 0x00000000_00000003.
- Reset mid-operation: rst=1 at T+5 → next cycle state FREE, result_o=0, ready_o=0, stallreq_o=0 with start_i low.
- Overflow and hold: DIV 0x80000000 / 0xFFFFFFFF → result_o = 0x00000000_80000000; start_i held 3 extra cycles → ready_o and result_o stable throughout.
